nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle adder for W = 4*NIBBLES bit operands. It processes one 4-bit nibble per clock, LSB nibble first.
- A registered carry links the nibbles, so one 4-bit carry-select slice is reused for the whole word.
- Sits in the bit-serial adder lab datapath. It is the control/shift stage that feeds the 4-bit carry-select slice and collects its sum and carry.
- Front-end (switches/registers) starts it with Run; it returns Sum/C_out with a Done pulse.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES; legal range 1..16.

Ports:
- Clk  input  1  system clock, rising-edge
- Reset_n  input  1  asynchronous, active-low reset
- Run  input  1  start request; an operation starts on a rising edge of Run
- A  input  W  operand A, sampled only on the start edge
- B  input  W  operand B, sampled only on the start edge
- C_in  input  1  carry-in, sampled only on the start edge
- Sum  output  W  registered result; holds until the next completion
- C_out  output  1  registered carry out of the MSB nibble
- Busy  output  1  high while nibbles are being processed
- Done  output  1  one-cycle pulse when Sum/C_out update

Behaviour:
- **Reset.** Reset_n low, asynchronous:
  - state=IDLE; Sum=0, C_out=0, Busy=0, Done=0.
  - Internal shift registers, carry register, nibble counter and Run_q all 0.
  - Reset mid-operation aborts immediately. Sum/C_out clear to 0 and no Done is produced.
- **Start detect.** Run_q is a registered copy of Run. start = Run & ~Run_q.
  - Holding Run high starts exactly one operation.
  - Run already high when Reset_n releases counts as a start.
  - Run edges while not IDLE are ignored. They are not queued.
- **IDLE.**
  - On an edge with start: load A_sh=A, B_sh=B, carry=C_in, cnt=0; go to CALC.
  - Otherwise stay in IDLE.
- **CALC** (Busy=1):
  - Each edge computes {c4,s4} = A_sh[3:0] + B_sh[3:0] + carry.
  - The computation is a carry-select slice: two 4-bit ripple sums with carry 0 and 1, muxed by the carry register. c4 = c_0 | (c_1 & carry).
  - Shift A_sh and B_sh right by 4.
  - Shift s4 into the top nibble of the partial-sum register S_sh (right shift).
  - carry <= c4; cnt <= cnt+1.
  - On the edge where cnt == NIBBLES-1: also load Sum <= final S_sh value and C_out <= c4, then go to DONE.
- **DONE** (Done=1, Busy=0): next edge returns to IDLE unconditionally.
  - A start seen on that edge is ignored, because the state was not IDLE.
  - Run must fall and rise again for a new operation.
- **Latency.**
  - Start sampled at edge 0. Busy is high from edge 0 through edge NIBBLES.
  - Sum, C_out and Done change at edge NIBBLES. Done drops at edge NIBBLES+1.
  - Minimum spacing between two starts is NIBBLES+2 edges.
- **Arithmetic.** Unsigned modulo 2^W plus C_in. C_out is the true carry out of bit W-1.
- **Sum stability.** Sum and C_out never show partial results during CALC. They keep the previous operation's value.
- **Input stability.** A, B and C_in may change freely after the start edge without affecting the result.
- **NIBBLES=1.** CALC lasts one edge, and Done appears at edge 1.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit), reset 0.
  - Overflow updates with Sum at completion to (carry into bit W-1) XOR (carry out of bit W-1). This is two's-complement overflow.
  - Otherwise it holds with Sum. It clears on reset.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan (NIBBLES=4):
- **Basic add.** Reset, then Run rise with A=0x1234, B=0x4321, C_in=0.
  - Busy high for edges 0..4.
  - Done pulse at edge 4 only; Sum=0x5555, C_out=0.
- **Full carry chain.** A=0xFFFF, B=0x0001, C_in=0 -> Sum=0x0000, C_out=1.
  - Then A=0x0000, B=0x0000, C_in=1 -> Sum=0x0001, C_out=0.
- **Held Run and input changes.** Hold Run high for 20 cycles with A=0x00FF, B=0x0F0F; change A/B after edge 0.
  - Exactly one Done; Sum=0x100E, C_out=0.
  - Sum unchanged during the following CALC-free cycles.
- **Reset mid-operation.** Start A=0x8888, B=0x8888, then assert Reset_n low after edge 2.
  - Outputs are 0 immediately, and there is no Done.
  - After release with Run low then high, A=0x8888, B=0x8888 -> Sum=0x1110, C_out=1.
- **Run edge while busy.** Pulse Run low/high at edge 2 of an operation.
  - It is ignored: a single Done, and the next start is accepted only from IDLE.
- **Overflow (SIGNED_OVF_EN).**
  - A=0x7FFF, B=0x0001 -> Sum=0x8000, Overflow=1, C_out=0.
  - A=0xFFFF, B=0x0001 -> Overflow=0, C_out=1.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_if
// Bus bundle between the lab front-end (switches/registers) and the
// nibble-serial adder.
//   master : front-end side, drives Run/A/B/C_in, observes the result
//   slave  : adder side, samples Run/A/B/C_in, drives Sum/C_out/Busy/Done
// Signals:
//   Run      start request (operation starts on its rising edge)
//   A, B     W-bit operands, W = 4*NIBBLES
//   C_in     carry-in
//   Sum      registered W-bit result
//   C_out    registered carry out of bit W-1
//   Busy     high while nibbles are being processed
//   Done     one-cycle pulse when Sum/C_out update
//   Overflow two's-complement overflow, present only with SIGNED_OVF_EN
// ----------------------------------------------------------------------------
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         Run;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic [W-1:0] Sum;
    logic         C_out;
    logic         Busy;
    logic         Done;
`ifdef SIGNED_OVF_EN
    logic         Overflow;
`endif

    modport master (
        output Run, A, B, C_in,
`ifdef SIGNED_OVF_EN
        input  Overflow,
`endif
        input  Sum, C_out, Busy, Done
    );

    modport slave (
        input  Run, A, B, C_in,
`ifdef SIGNED_OVF_EN
        output Overflow,
`endif
        output Sum, C_out, Busy, Done
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle adder for W = 4*NIBBLES bit operands. One 4-bit carry-select
// slice is reused for every nibble, LSB nibble first, with a registered
// carry linking consecutive nibbles. A rising edge of Run starts an
// operation; Sum/C_out update together with a one-cycle Done pulse.
// Ports:
//   Clk      system clock, rising edge
//   Reset_n  asynchronous, active-low reset
//   bus      nibble_serial_adder_if.slave (Run, A, B, C_in, Sum, C_out,
//            Busy, Done [, Overflow])
// Parameters:
//   NIBBLES  number of 4-bit slices per operand, 1..16
// Configuration:
//   SIGNED_OVF_EN  when defined, adds the Overflow output (two's-complement
//                  overflow of the final result).
// ----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic           run_q, run_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   s_sh_q, s_sh_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           c_out_q, c_out_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef SIGNED_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    // Carry-select slice: both candidate sums are formed in parallel and
    // the registered carry picks one.
    logic [4:0]     sum_c0, sum_c1;
    logic [3:0]     s4;
    logic           c4;
    logic [W-1:0]   s_next;
    logic           start;

    always_comb begin
        sum_c0 = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]};
        sum_c1 = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + 5'd1;
        s4     = carry_q ? sum_c1[3:0] : sum_c0[3:0];
        c4     = sum_c0[4] | (sum_c1[4] & carry_q);
        // New nibble enters at the top; the size cast drops the nibble
        // shifted out at the bottom (also valid when NIBBLES == 1).
        s_next = W'({s4, s_sh_q} >> 4);
        start  = bus.Run & ~run_q;
    end

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the
        // case below can leave it unassigned and infer a latch.
        state_d = state_q;
        run_d   = bus.Run;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B;
                    carry_d = bus.C_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                s_sh_d  = s_next;
                carry_d = c4;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    sum_d   = s_next;
                    c_out_d = c4;
`ifdef SIGNED_OVF_EN
                    // Carry into bit W-1 is recovered from the sum bit:
                    // s = a ^ b ^ cin.
                    ovf_d   = (s4[3] ^ a_sh_q[3] ^ b_sh_q[3]) ^ c4;
`endif
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.Sum   = sum_q;
    assign bus.C_out = c_out_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
`ifdef SIGNED_OVF_EN
    assign bus.Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Bench for nibble_serial_adder with NIBBLES = 4. Directed vector table,
// hand-written multi-cycle sequences (held Run, mid-operation reset, Run
// edge while busy) and random operands checked against a plain-arithmetic
// model. Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: whole-word arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] sum, output logic cout, output logic ovf);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum  = full[W-1:0];
        cout = full[W];
        ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    endtask

    // One operation: start, scramble inputs after the start edge, then
    // check Busy/Done timing, Sum stability and the final result.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        @(negedge Clk);
        prev_sum  = bus.Sum;
        prev_cout = bus.C_out;
        bus.A = a; bus.B = b; bus.C_in = cin; bus.Run = 1'b1;
        @(negedge Clk);                       // after edge 0
        check({name, " busy@0"}, 32'(bus.Busy), 32'd1);
        bus.Run  = 1'b0;
        bus.A    = W'($urandom);
        bus.B    = W'($urandom);
        bus.C_in = 1'($urandom);
        for (int k = 1; k <= NIBBLES; k++) begin
            @(negedge Clk);
            if (k < NIBBLES) begin
                check({name, " busy mid"}, 32'(bus.Busy), 32'd1);
                check({name, " done mid"}, 32'(bus.Done), 32'd0);
                check({name, " sum hold"}, 32'({bus.C_out, bus.Sum}), 32'({prev_cout, prev_sum}));
            end
        end
        check({name, " done"}, 32'(bus.Done), 32'd1);
        check({name, " busy end"}, 32'(bus.Busy), 32'd0);
        check({name, " sum"}, 32'(bus.Sum), 32'(es));
        check({name, " c_out"}, 32'(bus.C_out), 32'(ec));
`ifdef SIGNED_OVF_EN
        check({name, " ovf"}, 32'(bus.Overflow), 32'(eo));
`else
        if (eo === 1'bx) $display("unused overflow expectation");
`endif
        @(negedge Clk);
        check({name, " done drop"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int dones;
        logic [W-1:0] rs, ra, rb;
        logic rc, rcin, ro;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

        Reset_n = 1'b0;
        bus.Run = 1'b0; bus.A = '0; bus.B = '0; bus.C_in = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset sum",   32'(bus.Sum),   32'd0);
        check("reset c_out", 32'(bus.C_out), 32'd0);
        check("reset busy",  32'(bus.Busy),  32'd0);
        check("reset done",  32'(bus.Done),  32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Held Run: one operation only, inputs changed after edge 0.
        @(negedge Clk);
        bus.A = 16'h00FF; bus.B = 16'h0F0F; bus.C_in = 1'b0; bus.Run = 1'b1;
        @(negedge Clk);
        bus.A = 16'hAAAA; bus.B = 16'h5555;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.Done) dones++;
            @(negedge Clk);
        end
        check("held done count", 32'(dones), 32'd1);
        check("held sum",   32'(bus.Sum),   32'h100E);
        check("held c_out", 32'(bus.C_out), 32'd0);
        check("held busy",  32'(bus.Busy),  32'd0);
        bus.Run = 1'b0;
        @(negedge Clk);

        // Reset mid-operation.
        bus.A = 16'h8888; bus.B = 16'h8888; bus.C_in = 1'b0; bus.Run = 1'b1;
        @(negedge Clk);                       // after edge 0
        @(negedge Clk);                       // after edge 1
        @(negedge Clk);                       // after edge 2
        bus.Run = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("abort sum",  32'(bus.Sum),  32'd0);
        check("abort busy", 32'(bus.Busy), 32'd0);
        check("abort done", 32'(bus.Done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (bus.Done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort idle sum", 32'(bus.Sum), 32'd0);
        run_op("after reset", 16'h8888, 16'h8888, 1'b0, 16'h1110, 1'b1, 1'b1);

        // Run edge while busy is ignored.
        @(negedge Clk);
        bus.A = 16'h0102; bus.B = 16'h0304; bus.C_in = 1'b0; bus.Run = 1'b1;
        @(negedge Clk);                       // after edge 0
        @(negedge Clk);                       // after edge 1
        bus.Run = 1'b0;
        @(negedge Clk);                       // after edge 2
        bus.Run = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (bus.Done) dones++;
        end
        check("busy edge done count", 32'(dones), 32'd1);
        check("busy edge sum", 32'(bus.Sum), 32'h0406);
        check("busy edge idle", 32'(bus.Busy), 32'd0);
        bus.Run = 1'b0;
        @(negedge Clk);
        run_op("post busy edge", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);

        // Random operands against the model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
            model(ra, rb, rcin, rs, rc, ro);
            run_op($sformatf("rand%0d", i), ra, rb, rcin, rs, rc, ro);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
